// File: rtl/multimode_counter_if.sv
// rtl/multimode_counter_if.sv - control/status bundle for multimode_counter
interface multimode_counter_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
);
    logic             clr;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] term_val;
    logic [PSC_W-1:0] presc;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             running;
    logic             sat;

    modport master (
        output clr, en, load, load_val, dir, mode, term_val, presc,
        input  count, tick, done, running, sat
    );

    modport slave (
        input  clr, en, load, load_val, dir, mode, term_val, presc,
        output count, tick, done, running, sat
    );
endinterface

// File: rtl/multimode_counter.sv
// rtl/multimode_counter.sv - prescaled up/down counter with wrap, saturate and one-shot terminal modes
module multimode_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    multimode_counter_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_STOP} state_t;

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PSC_W-1:0] r_psc;
    logic             r_tick;
    logic             r_done;
    logic             r_running;
    logic             r_sat;
    logic             r_dir_prev;

    logic w_step;
    logic w_at_term;
    logic w_dir_chg;
    logic w_sat_eff;

    assign w_step    = bus.en && (r_state == ST_RUN) && (r_psc == bus.presc);
    assign w_at_term = bus.dir ? (r_count >= bus.term_val) : (r_count == '0);
    assign w_dir_chg = bus.dir != r_dir_prev;
    // a direction change drops sat before this cycle's step decides whether to re-arm it
    assign w_sat_eff = r_sat && !w_dir_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_count    <= '0;
            r_psc      <= '0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_running  <= 1'b1;
            r_sat      <= 1'b0;
            r_dir_prev <= 1'b0;
        end else begin
            r_dir_prev <= bus.dir;
            if (bus.clr || bus.load) begin
                r_state   <= ST_RUN;
                r_count   <= bus.clr ? '0 : bus.load_val;
                r_psc     <= '0;
                r_tick    <= 1'b0;
                r_done    <= 1'b0;
                r_running <= 1'b1;
                r_sat     <= 1'b0;
            end else begin
                r_tick <= w_step;
                r_done <= 1'b0;
                r_sat  <= w_sat_eff;
                if (bus.en && r_state == ST_RUN) begin
                    r_psc <= (r_psc == bus.presc) ? '0 : r_psc + 1'b1;
                end
                if (w_step) begin
                    if (!w_at_term) begin
                        r_count <= bus.dir ? r_count + 1'b1 : r_count - 1'b1;
                        r_sat   <= 1'b0;
                    end else begin
                        case (bus.mode)
                            MODE_SAT: begin
                                if (!w_sat_eff) begin
                                    r_done <= 1'b1;
                                    r_sat  <= 1'b1;
                                end
                            end
                            MODE_ONCE: begin
                                r_done    <= 1'b1;
                                r_state   <= ST_STOP;
                                r_running <= 1'b0;
                            end
                            default: begin
                                r_count <= bus.dir ? '0 : bus.term_val;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.tick    = r_tick;
    assign bus.done    = r_done;
    assign bus.running = r_running;
    assign bus.sat     = r_sat;
endmodule

// File: tb/tb_multimode_counter.sv
// tb/tb_multimode_counter.sv - scoreboard bench for multimode_counter with a behavioural model
module tb_multimode_counter;
    localparam int W = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multimode_counter_if #(.WIDTH(W), .PSC_W(P)) bus ();
    multimode_counter #(.WIDTH(W), .PSC_W(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [W-1:0] count;
        logic         tick;
        logic         done;
        logic         running;
        logic         sat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    event chk_now;

    int m_count, m_psc;
    bit m_stop, m_sat, m_pdir, m_tick, m_done;

    function automatic void m_reset();
        m_count = 0; m_psc = 0; m_stop = 0; m_sat = 0; m_pdir = 0; m_tick = 0; m_done = 0;
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e.count   = m_count[W-1:0];
        e.tick    = m_tick;
        e.done    = m_done;
        e.running = !m_stop;
        e.sat     = m_sat;
        return e;
    endfunction

    function automatic void m_step();
        int  term, maxv;
        bit  up, hit, at_term;
        maxv = 1 << W;
        up   = bus.dir;
        term = int'(bus.term_val);
        m_tick = 0;
        m_done = 0;
        if (bus.clr || bus.load) begin
            m_count = bus.clr ? 0 : int'(bus.load_val);
            m_psc = 0; m_stop = 0; m_sat = 0;
        end else begin
            if (up != m_pdir) m_sat = 0;
            hit = bus.en && !m_stop && (m_psc == int'(bus.presc));
            if (bus.en && !m_stop) m_psc = hit ? 0 : (m_psc + 1) % (1 << P);
            if (hit) begin
                m_tick  = 1;
                at_term = up ? (m_count >= term) : (m_count == 0);
                if (!at_term) begin
                    m_count = (m_count + (up ? 1 : maxv - 1)) % maxv;
                    m_sat   = 0;
                end else if (bus.mode == 2'b01) begin
                    if (!m_sat) begin m_done = 1; m_sat = 1; end
                end else if (bus.mode == 2'b10) begin
                    m_done = 1; m_stop = 1;
                end else begin
                    m_count = up ? 0 : term;
                    m_done  = 1;
                end
            end
        end
        m_pdir = up;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cyc=%0d %s actual=%0d expected=%0d", cyc, name, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_now);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count",   32'(bus.count),   32'(e.count));
                chk("tick",    32'(bus.tick),    32'(e.tick));
                chk("done",    32'(bus.done),    32'(e.done));
                chk("running", 32'(bus.running), 32'(e.running));
                chk("sat",     32'(bus.sat),     32'(e.sat));
            end
        end
    end

    // called at a negedge: predict the next posedge result, then advance to the following negedge
    task automatic cycle(int n = 1);
        for (int i = 0; i < n; i++) begin
            if (!rst_n) m_reset(); else m_step();
            q.push_back(m_out());
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        m_reset();
        q.push_back(m_out());
        -> chk_now;
        @(negedge clk);
        cyc++;
        cycle(1);
        rst_n = 1'b1;
    endtask

    task automatic setup(bit c, bit l, int lv, bit en, bit d, int md, int tv, int ps);
        bus.clr = c; bus.load = l; bus.load_val = lv[W-1:0]; bus.en = en; bus.dir = d;
        bus.mode = md[1:0]; bus.term_val = tv[W-1:0]; bus.presc = ps[P-1:0];
    endtask

    initial begin
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        cycle(2);
        rst_n = 1'b1;

        // wrap up to 5 at full rate
        setup(0, 0, 0, 1, 1, 0, 5, 0);
        cycle(8);
        // prescaler /4 with an en gap
        setup(1, 0, 0, 1, 1, 0, 255, 3); cycle(1);
        bus.clr = 0; cycle(16);
        bus.en = 0; cycle(2);
        bus.en = 1; cycle(8);
        // saturate down from 3, then reverse
        setup(0, 1, 3, 1, 0, 1, 10, 0); cycle(1);
        bus.load = 0; cycle(6);
        bus.dir = 1; cycle(3);
        // one-shot up to 2, stop, reload
        setup(1, 0, 0, 1, 1, 2, 2, 0); cycle(1);
        bus.clr = 0; cycle(14);
        bus.load = 1; bus.load_val = 0; cycle(1);
        bus.load = 0; cycle(3);
        // priority and boundaries
        setup(0, 0, 0, 1, 1, 0, 10, 0); cycle(4);
        bus.clr = 1; bus.load = 1; bus.load_val = 7; cycle(1);
        setup(0, 1, 9, 1, 1, 0, 4, 0); cycle(1);
        bus.load = 0; cycle(3);
        bus.term_val = 0; cycle(4);
        bus.dir = 0; cycle(3);
        // async reset mid-count, then prescaled restart
        setup(1, 0, 0, 1, 1, 0, 255, 2); cycle(1);
        bus.clr = 0; cycle(21);
        async_reset();
        cycle(7);

        for (int i = 0; i < 3000; i++) begin
            bus.clr  = ($urandom_range(0, 31) == 0);
            bus.load = ($urandom_range(0, 15) == 0);
            bus.load_val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
            bus.en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0)
                bus.term_val = ($urandom_range(0, 7) == 0) ? 8'd255 : W'($urandom_range(0, 12));
            if ($urandom_range(0, 63) == 0)
                bus.presc = ($urandom_range(0, 7) == 0) ? P'($urandom) : P'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle(1);
        end

        setup(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
Parametrised successor to the team's basic wrap counter. Adds up/down counting, a programmable terminal value, a parallel load and a built-in prescaler. Supports three terminal modes: wrap, saturate and one-shot. Used as the general timing/event counter in datapath controllers, where the old fixed-max counter is too rigid.

Parameters:
WIDTH, 8, width of count, load_val and term_val
PSC_W, 4, width of the prescaler divide field

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear
en  input  1  count enable (gates the prescaler)
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded into count
dir  input  1  1 = count up, 0 = count down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
term_val  input  WIDTH  terminal value for up counting and reload value for down wrap
presc  input  PSC_W  step every presc+1 enabled cycles
count  output  WIDTH  current count (registered)
tick  output  1  registered one-cycle pulse each cycle count was stepped
done  output  1  registered one-cycle pulse on terminal event
running  output  1  high in RUN state
sat  output  1  high while held at terminal in saturate mode

Behaviour:
- Reset (rst_n low, async): count=0, psc=0, tick=0, done=0, sat=0, state=RUN, running=1.
- Priority per edge: rst_n > clr > load > step.
- clr: count=0, psc=0, done=0, tick=0, sat=0, state=RUN.
- load: count=load_val, psc=0, done=0, tick=0, sat=0, state=RUN. Ignores en.
- Prescaler: internal psc (PSC_W bits).
  - When en=1 and state=RUN: if psc==presc, then psc<=0 and step=1 for this cycle; otherwise psc<=psc+1.
  - en=0 freezes psc.
  - presc=0 gives a step on every enabled cycle.
  - step is internal and combinational.
- Terminal condition, evaluated on the current count:
  - up: count >= term_val (covers count loaded above term_val)
  - down: count == 0
- Step with no terminal condition: count +/- 1, tick=1 next cycle.
- Step at terminal, by mode (mode and dir are sampled at each step; changing them mid-run takes effect on the next step):
  - wrap: up -> count=0; down -> count=term_val; done=1.
  - saturate: count holds. If sat==0, then done=1 and sat=1. If sat==1, no done. tick=1 in both cases.
  - one-shot: count holds, done=1, state->STOP. running=0 from the next cycle.
- STOP state: no steps, psc frozen, count held. Exits to RUN only on clr or load.
- sat clears on clr, load, a dir change, or a step taken while not at terminal.
- done and tick are registered. They are high exactly the cycle after the step edge, aligned with the updated count. Both are 0 on every cycle without a step.
- Edge cases:
  - term_val=0 counting up: every step is terminal (wrap -> done on every step).
  - Down wrap with term_val=0: count stays 0 and done pulses every step.
- Arithmetic is modulo 2^WIDTH. Overflow cannot occur because terminal checks precede the increment/decrement. All comparisons are unsigned.
- Reset asserted mid-count or in STOP returns immediately to the reset values. No residual done pulse after release.
- Latency: load or clr to count visible = 1 cycle. en rising to first step = presc+1 enabled cycles from psc=0.

Test Plan:
1. Wrap up: WIDTH=8, presc=0, mode=00, dir=1, term_val=5, en=1 from reset -> count 1,2,3,4,5,0,1; done high only the cycle count returns to 0; tick high every cycle.
2. Prescaler: presc=3, term_val=255, en held high for 16 cycles -> count=4; tick pulses every 4th cycle; toggling en low for 2 cycles delays the next tick by exactly 2 cycles.
3. Saturate down: load_val=3, mode=01, dir=0, presc=0 -> count 2,1,0,0,0; done single pulse as sat rises; sat stays 1; switching dir=1 clears sat and counts 1,2.
4. One-shot: mode=10, term_val=2, up from 0 -> count 1,2, then held at 2; done pulse; running=0; en stays high with no change for 10 cycles; load with load_val=0 -> running=1, counting resumes.
5. Priority/boundary: clr and load asserted together mid-count -> count=0. load_val=9 with term_val=4 in wrap up -> next step count=0 with done. term_val=0 up -> done every step.
6. Async reset: drop rst_n between clock edges during count=7 with presc=2 -> all outputs 0 and running=1 immediately; after release, first step occurs after 3 enabled cycles.
